// File: rtl/cache_port_arbiter_if.sv
// Requester and Cache handshake bundle for cache_port_arbiter.
// master: the arbiter's view. slave: the requesters and Cache as seen from outside.
interface cache_port_arbiter_if;
  logic        i_req_valid;
  logic [31:0] i_addr;
  logic        i_req_ready;
  logic        i_resp_valid;
  logic [31:0] i_dout;

  logic        d_req_valid;
  logic [31:0] d_addr;
  logic        d_rw;
  logic [31:0] d_din;
  logic        d_req_ready;
  logic        d_resp_valid;
  logic [31:0] d_dout;
  logic        d_hit;

  logic        c_req_valid;
  logic [31:0] c_addr;
  logic        c_rw;
  logic [31:0] c_din;
  logic        c_ready;
  logic        c_resp_valid;
  logic [31:0] c_dout;
  logic        c_hit;

  modport master (
    input  i_req_valid, i_addr,
    output i_req_ready, i_resp_valid, i_dout,
    input  d_req_valid, d_addr, d_rw, d_din,
    output d_req_ready, d_resp_valid, d_dout, d_hit,
    output c_req_valid, c_addr, c_rw, c_din,
    input  c_ready, c_resp_valid, c_dout, c_hit
  );

  modport slave (
    output i_req_valid, i_addr,
    input  i_req_ready, i_resp_valid, i_dout,
    output d_req_valid, d_addr, d_rw, d_din,
    input  d_req_ready, d_resp_valid, d_dout, d_hit,
    input  c_req_valid, c_addr, c_rw, c_din,
    output c_ready, c_resp_valid, c_dout, c_hit
  );
endinterface

// File: rtl/cache_port_arbiter.sv
// Shares one unified Cache between the I-fetch and D-memory requesters.
// One transaction in flight; D has priority, with a starvation guard for I.
// Saturating hit/miss statistics counters.
module cache_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  cache_port_arbiter_if.master bus,
  output logic [CNT_W-1:0]     hit_count,
  output logic [CNT_W-1:0]     miss_count
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [31:0]       addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [31:0]       din_q, din_d;
  logic [CNT_W-1:0]  hit_q, miss_q;

  logic              grant_i, grant_d, resp;
  logic              i_resp_valid, d_resp_valid, d_hit, c_req_valid;
  logic [31:0]       i_dout, d_dout;

  // State, starvation counter and latched request registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      starve_q <= '0;
      addr_q   <= '0;
      rw_q     <= 1'b0;
      din_q    <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      rw_q     <= rw_d;
      din_q    <= din_d;
    end
  end

  // Arbitration, next state and response routing
  always_comb begin
    state_d      = state_q;
    starve_d     = starve_q;
    addr_d       = addr_q;
    rw_d         = rw_q;
    din_d        = din_q;
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    resp         = 1'b0;
    c_req_valid  = 1'b0;
    i_resp_valid = 1'b0;
    i_dout       = '0;
    d_resp_valid = 1'b0;
    d_dout       = '0;
    d_hit        = 1'b0;
    case (state_q)
      IDLE: begin
        // grant is gated by reset so every output reads 0 while reset is held
        if (!reset && bus.c_ready) begin
          if (bus.d_req_valid && !(bus.i_req_valid && starve_q == LIMIT))
            grant_d = 1'b1;
          else if (bus.i_req_valid)
            grant_i = 1'b1;
        end
        if (grant_d) begin
          state_d = BUSY_D;
          addr_d  = bus.d_addr;
          rw_d    = bus.d_rw;
          din_d   = bus.d_din;
          if (bus.i_req_valid && starve_q != LIMIT)
            starve_d = starve_q + SW'(1);
        end else if (grant_i) begin
          state_d  = BUSY_I;
          addr_d   = bus.i_addr;
          rw_d     = 1'b0;
          din_d    = '0;
          starve_d = '0;
        end
      end
      BUSY_I: begin
        c_req_valid = 1'b1;
        if (bus.c_resp_valid) begin
          resp         = 1'b1;
          i_resp_valid = 1'b1;
          i_dout       = bus.c_dout;
          state_d      = IDLE;
        end
      end
      BUSY_D: begin
        c_req_valid = 1'b1;
        if (bus.c_resp_valid) begin
          resp         = 1'b1;
          d_resp_valid = 1'b1;
          d_dout       = bus.c_dout;
          d_hit        = bus.c_hit;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturating hit/miss counters, stepped once per completed access
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (resp) begin
      if (bus.c_hit) begin
        if (hit_q != '1) hit_q <= hit_q + CNT_W'(1);
      end else begin
        if (miss_q != '1) miss_q <= miss_q + CNT_W'(1);
      end
    end
  end

  assign bus.i_req_ready  = grant_i;
  assign bus.d_req_ready  = grant_d;
  assign bus.i_resp_valid = i_resp_valid;
  assign bus.i_dout       = i_dout;
  assign bus.d_resp_valid = d_resp_valid;
  assign bus.d_dout       = d_dout;
  assign bus.d_hit        = d_hit;
  assign bus.c_req_valid  = c_req_valid;
  assign bus.c_addr       = addr_q;
  assign bus.c_rw         = rw_q;
  assign bus.c_din        = din_q;
  assign hit_count        = hit_q;
  assign miss_count       = miss_q;

endmodule
